// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and width helpers for the pipelined multiply-accumulate engine.
// Widths are per-instance parameters, so the helpers are functions rather than fixed constants.
package lcv_mul_acc_pkg;

    localparam int MAX_WIDTH = 128;

    // Control that travels with each beat; the data word rides alongside at its instance width.
    typedef struct packed {
        logic first;
        logic last;
        logic ovf;
    } stage_ctrl_t;

    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

    function automatic int latency(input int mul_regs);
        return 3 + mul_regs;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // Low 'width' bits hold -2^(width-1); the upper bits are its sign extension.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/lcv_mul_acc_pipe_if.sv
// Beat input and result output bundle for lcv_mul_acc_pipe.
// The slave modport is the engine's view; master is the producer/consumer view.
interface lcv_mul_acc_pipe_if #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_WIDTH-1:0]   in_a;
    logic signed [B_WIDTH-1:0]   in_b;
    logic signed [ACC_WIDTH-1:0] in_c;
    logic                        in_first;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/lcv_sat_add.sv
// Combinational signed adder with overflow detect and optional clamping.
module lcv_sat_add
    import lcv_mul_acc_pkg::*;
#(
    parameter int WIDTH    = 40,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o,
    output logic                    ovf_o
);
    localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    logic signed [WIDTH-1:0] raw;
    logic                    ovf;

    // Overflow only when both operands share a sign and the wrapped result does not.
    always_comb begin
        raw   = a_i + b_i;
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
        sum_o = raw;
        if (SATURATE && ovf) begin
            sum_o = a_i[WIDTH-1] ? MIN_V : MAX_V;
        end
        ovf_o = ovf;
    end
endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate: S1 -> M1..Mn (product) -> T (p+c) -> ACC (running sum).
// A sum is framed by first/last; only the value closed by a last beat is presented on the output.
module lcv_mul_acc_pipe
    import lcv_mul_acc_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int MUL_REGS  = 1,
    parameter bit SATURATE  = 1'b1
) (
    input logic                clk,
    input logic                rst,
    lcv_mul_acc_pipe_if.slave  bus
);
    localparam int PROD_WIDTH = prod_width(A_WIDTH, B_WIDTH);

    logic stall;

    // ---------------- S1: operand capture ----------------
    logic                         s1_valid_q;
    stage_ctrl_t                  s1_ctrl_q;
    logic signed [A_WIDTH-1:0]    s1_a_q;
    logic signed [B_WIDTH-1:0]    s1_b_q;
    logic signed [ACC_WIDTH-1:0]  s1_c_q;

    // ---------------- product stage outputs feeding T ----------------
    logic signed [PROD_WIDTH-1:0] prod_w;
    logic                         mt_valid;
    stage_ctrl_t                  mt_ctrl;
    logic signed [PROD_WIDTH-1:0] mt_prod;
    logic signed [ACC_WIDTH-1:0]  mt_c;

    // ---------------- T stage ----------------
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  t_sum;
    logic                         t_ovf;
    logic                         t_valid_q;
    stage_ctrl_t                  t_ctrl_q;
    logic signed [ACC_WIDTH-1:0]  t_data_q;

    // ---------------- ACC stage ----------------
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic                         acc_ovf;
    logic                         ovf_run;
    logic signed [ACC_WIDTH-1:0]  acc_q,       acc_d;
    logic                         ovf_run_q,   ovf_run_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                         out_ovf_q,   out_ovf_d;

    // A held result freezes every stage so nothing behind it is lost.
    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = rst && !stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= bus.in_valid;
            s1_a_q     <= bus.in_a;
            s1_b_q     <= bus.in_b;
            s1_c_q     <= bus.in_c;
            s1_ctrl_q  <= '{first: bus.in_first, last: bus.in_last, ovf: 1'b0};
        end
    end

    // Full-width operands make the product exact; A_WIDTH+B_WIDTH bits cannot overflow.
    assign prod_w = PROD_WIDTH'(s1_a_q) * PROD_WIDTH'(s1_b_q);

    generate
        if (MUL_REGS == 0) begin : g_no_mreg
            assign mt_valid = s1_valid_q;
            assign mt_ctrl  = s1_ctrl_q;
            assign mt_prod  = prod_w;
            assign mt_c     = s1_c_q;
        end else begin : g_mreg
            logic                         m_valid_q [MUL_REGS];
            stage_ctrl_t                  m_ctrl_q  [MUL_REGS];
            logic signed [PROD_WIDTH-1:0] m_prod_q  [MUL_REGS];
            logic signed [ACC_WIDTH-1:0]  m_c_q     [MUL_REGS];

            (* use_dsp48 = "yes" *)
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < MUL_REGS; i++) begin
                        m_valid_q[i] <= 1'b0;
                    end
                end else if (!stall) begin
                    m_valid_q[0] <= s1_valid_q;
                    m_ctrl_q[0]  <= s1_ctrl_q;
                    m_prod_q[0]  <= prod_w;
                    m_c_q[0]     <= s1_c_q;
                    for (int i = 1; i < MUL_REGS; i++) begin
                        m_valid_q[i] <= m_valid_q[i-1];
                        m_ctrl_q[i]  <= m_ctrl_q[i-1];
                        m_prod_q[i]  <= m_prod_q[i-1];
                        m_c_q[i]     <= m_c_q[i-1];
                    end
                end
            end

            assign mt_valid = m_valid_q[MUL_REGS-1];
            assign mt_ctrl  = m_ctrl_q[MUL_REGS-1];
            assign mt_prod  = m_prod_q[MUL_REGS-1];
            assign mt_c     = m_c_q[MUL_REGS-1];
        end
    endgenerate

    assign prod_ext = ACC_WIDTH'(mt_prod);

    lcv_sat_add #(
        .WIDTH    (ACC_WIDTH),
        .SATURATE (SATURATE)
    ) u_add_t (
        .a_i   (prod_ext),
        .b_i   (mt_c),
        .sum_o (t_sum),
        .ovf_o (t_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_valid_q <= 1'b0;
        end else if (!stall) begin
            t_valid_q <= mt_valid;
            t_data_q  <= t_sum;
            t_ctrl_q  <= '{first: mt_ctrl.first, last: mt_ctrl.last, ovf: mt_ctrl.ovf | t_ovf};
        end
    end

    // A first beat ignores whatever running sum and overflow history precede it.
    assign acc_base = t_ctrl_q.first ? '0 : acc_q;
    assign ovf_run  = (t_ctrl_q.first ? 1'b0 : ovf_run_q) | t_ctrl_q.ovf | acc_ovf;

    lcv_sat_add #(
        .WIDTH    (ACC_WIDTH),
        .SATURATE (SATURATE)
    ) u_add_acc (
        .a_i   (acc_base),
        .b_i   (t_data_q),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    always_comb begin
        acc_d       = acc_q;
        ovf_run_d   = ovf_run_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (!stall) begin
            // Unstalled means the current result (if any) is consumed this cycle.
            out_valid_d = 1'b0;
            if (t_valid_q) begin
                if (t_ctrl_q.last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_sum;
                    out_ovf_d   = ovf_run;
                    acc_d       = '0;
                    ovf_run_d   = 1'b0;
                end else begin
                    acc_d       = acc_sum;
                    ovf_run_d   = ovf_run;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q       <= '0;
            ovf_run_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_run_q   <= ovf_run_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Bench for lcv_mul_acc_pipe: saturating and wrapping instances driven in lockstep,
// results scoreboarded against a range-checking integer model.
module tb_lcv_mul_acc_pipe;
    import lcv_mul_acc_pkg::*;

    localparam int AW  = 16;
    localparam int BW  = 16;
    localparam int CW  = 40;
    localparam int MR  = 1;
    localparam int LAT = latency(MR);
    localparam longint MAXC = (longint'(1) <<< (CW - 1)) - 1;

    typedef struct {
        logic [CW-1:0] data;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid_drv = 1'b0;
    logic signed [AW-1:0]  in_a_drv = '0;
    logic signed [BW-1:0]  in_b_drv = '0;
    logic signed [CW-1:0]  in_c_drv = '0;
    logic                  in_first_drv = 1'b0;
    logic                  in_last_drv = 1'b0;
    logic                  out_ready_drv = 1'b1;

    int     checks = 0;
    int     errors = 0;
    exp_t   q_sat[$];
    exp_t   q_wrap[$];
    longint acc_m [2];
    bit     ovf_m [2];
    int     bp_hold = 0;
    bit     bp_random = 1'b0;
    bit     saw_stall = 1'b0;

    lcv_mul_acc_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) bus_sat ();
    lcv_mul_acc_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) bus_wrap ();

    assign bus_sat.in_valid   = in_valid_drv;
    assign bus_sat.in_a       = in_a_drv;
    assign bus_sat.in_b       = in_b_drv;
    assign bus_sat.in_c       = in_c_drv;
    assign bus_sat.in_first   = in_first_drv;
    assign bus_sat.in_last    = in_last_drv;
    assign bus_sat.out_ready  = out_ready_drv;
    assign bus_wrap.in_valid  = in_valid_drv;
    assign bus_wrap.in_a      = in_a_drv;
    assign bus_wrap.in_b      = in_b_drv;
    assign bus_wrap.in_c      = in_c_drv;
    assign bus_wrap.in_first  = in_first_drv;
    assign bus_wrap.in_last   = in_last_drv;
    assign bus_wrap.out_ready = out_ready_drv;

    lcv_mul_acc_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW), .MUL_REGS(MR), .SATURATE(1'b1)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    lcv_mul_acc_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW), .MUL_REGS(MR), .SATURATE(1'b0)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_wrap)
    );

    // Fit an exact value into CW signed bits by clamping or wrapping.
    function automatic longint fit(input bit sat, input longint x, output bit o);
        longint maxv;
        longint minv;
        longint w;
        maxv = MAXC;
        minv = -MAXC - 1;
        o = (x > maxv) || (x < minv);
        if (!o) return x;
        if (sat) return (x > maxv) ? maxv : minv;
        w = x & ((longint'(1) <<< CW) - 1);
        if (w > maxv) w = w - (longint'(1) <<< CW);
        return w;
    endfunction

    function automatic void model_beat(input bit sat, input longint a, input longint b, input longint c,
                                       input bit first, input bit last,
                                       inout longint acc, inout bit ovf, output bit emit, output exp_t e);
        longint t;
        longint s;
        bit     ot;
        bit     oa;
        t   = fit(sat, a * b + c, ot);
        s   = fit(sat, (first ? 0 : acc) + t, oa);
        ovf = (first ? 1'b0 : ovf) | ot | oa;
        e.data = CW'(s);
        e.ovf  = ovf;
        emit   = last;
        if (last) begin
            acc = 0;
            ovf = 1'b0;
        end else begin
            acc = s;
        end
    endfunction

    // Out-ready driver: forced low window, random, or always ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold > 0) begin
                out_ready_drv = 1'b0;
                bp_hold--;
            end else if (bp_random) begin
                out_ready_drv = ($urandom_range(0, 9) < 7);
            end else begin
                out_ready_drv = 1'b1;
            end
        end
    end

    // Output monitor: pop and compare on each handshake, check hold stability while stalled.
    initial begin : monitor
        logic          v, r, o, irdy;
        logic [CW-1:0] d;
        exp_t          e;
        bit            got;
        string         nm;
        logic          held   [2];
        logic [CW-1:0] held_d [2];
        logic          held_o [2];
        held = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    v = bus_sat.out_valid; r = bus_sat.out_ready; d = bus_sat.out_data;
                    o = bus_sat.out_ovf;   irdy = bus_sat.in_ready; nm = "sat";
                end else begin
                    v = bus_wrap.out_valid; r = bus_wrap.out_ready; d = bus_wrap.out_data;
                    o = bus_wrap.out_ovf;   irdy = bus_wrap.in_ready; nm = "wrap";
                end
                if (v && !r) begin
                    if (!irdy) saw_stall = 1'b1;
                    if (held[k]) begin
                        checks++;
                        if (d !== held_d[k] || o !== held_o[k]) begin
                            errors++;
                            $display("FAIL %s hold_stable: data=%h ovf=%b required data=%h ovf=%b", nm, d, o, held_d[k], held_o[k]);
                        end
                    end
                    held[k] = 1'b1; held_d[k] = d; held_o[k] = o;
                end else begin
                    held[k] = 1'b0;
                end
                if (v && r) begin
                    checks++;
                    got = 1'b0;
                    if (k == 0 && q_sat.size() != 0) begin e = q_sat.pop_front(); got = 1'b1; end
                    if (k == 1 && q_wrap.size() != 0) begin e = q_wrap.pop_front(); got = 1'b1; end
                    if (!got) begin
                        errors++;
                        $display("FAIL %s unexpected_output: data=%h ovf=%b required no result", nm, d, o);
                    end else if (d !== e.data || o !== e.ovf) begin
                        errors++;
                        $display("FAIL %s result: data=%h ovf=%b required data=%h ovf=%b", nm, d, o, e.data, e.ovf);
                    end else begin
                        $display("result %s data=%h ovf=%b", nm, d, o);
                    end
                end
            end
        end
    end

    // Present one beat, wait (bounded) for acceptance, update model on the accepting edge.
    task automatic send(input longint a, input longint b, input longint c, input bit first, input bit last);
        exp_t e;
        bit   emit;
        int   n;
        in_valid_drv = 1'b1;
        in_a_drv     = AW'(a);
        in_b_drv     = BW'(b);
        in_c_drv     = CW'(c);
        in_first_drv = first;
        in_last_drv  = last;
        n = 0;
        @(negedge clk);
        while (!bus_sat.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus_sat.in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=0 after %0d cycles required 1", n);
        end else begin
            model_beat(1'b1, a, b, c, first, last, acc_m[0], ovf_m[0], emit, e);
            if (emit) q_sat.push_back(e);
            model_beat(1'b0, a, b, c, first, last, acc_m[1], ovf_m[1], emit, e);
            if (emit) q_wrap.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid_drv = 1'b0;
        in_first_drv = 1'b0;
        in_last_drv  = 1'b0;
    endtask

    task automatic wait_out(input string what, output int cycles);
        cycles = 1;
        while (!bus_sat.out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (!bus_sat.out_valid) begin
            errors++;
            $display("FAIL %s out_valid_timeout: out_valid=0 after %0d cycles required 1", what, cycles);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (q_sat.size() != 0 || q_wrap.size() != 0) begin
            errors++;
            $display("FAIL drain: pending sat=%0d wrap=%0d required 0 0", q_sat.size(), q_wrap.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid_drv = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_sat.in_ready !== 1'b0 || bus_sat.out_valid !== 1'b0 || bus_sat.out_data !== '0 ||
                bus_wrap.out_valid !== 1'b0 || bus_wrap.out_data !== '0) begin
                errors++;
                $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h required 0 0 0",
                         bus_sat.in_ready, bus_sat.out_valid, bus_sat.out_data);
            end
        end
        idle_in();
        rst = 1'b1;
        acc_m = '{0, 0};
        ovf_m = '{1'b0, 1'b0};
        #1;
        checks++;
        if (bus_sat.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", bus_sat.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dot_product();
        int k;
        for (int i = 1; i <= 4; i++) send(i, 2, 0, i == 1, i == 4);
        idle_in();
        wait_out("dot_product", k);
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL dot_latency: cycles=%0d required %0d", k, LAT);
        end
        checks++;
        if (bus_sat.out_data !== CW'(20) || bus_sat.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL dot_value: data=%h ovf=%b required %h 0", bus_sat.out_data, bus_sat.out_ovf, CW'(20));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int k;
        send(-3, 7, 100, 1'b1, 1'b1);
        idle_in();
        wait_out("single_beat", k);
        checks++;
        if (bus_sat.out_data !== CW'(79) || bus_wrap.out_data !== CW'(79)) begin
            errors++;
            $display("FAIL single_beat: data=%h required %h", bus_sat.out_data, CW'(79));
        end
        drain();
        for (int i = 0; i < 3; i++) send(-3, 7, 100 + i, 1'b1, 1'b1);
        idle_in();
        wait_out("back_to_back", k);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus_sat.out_valid !== 1'b1 || bus_sat.out_data !== CW'(79 + i)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b data=%h required 1 %h", i, bus_sat.out_valid, bus_sat.out_data, CW'(79 + i));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus_sat.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_extra: out_valid=%b required 0", bus_sat.out_valid);
        end
        drain();
    endtask

    task automatic test_saturation();
        int k;
        send(0, 0, MAXC, 1'b1, 1'b0);
        send(1, 1, 0, 1'b0, 1'b1);
        idle_in();
        wait_out("saturation", k);
        checks++;
        if (bus_sat.out_data !== CW'(MAXC) || bus_sat.out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp: data=%h ovf=%b required %h 1", bus_sat.out_data, bus_sat.out_ovf, CW'(MAXC));
        end
        checks++;
        if (bus_wrap.out_data !== CW'(-MAXC - 1) || bus_wrap.out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_value: data=%h ovf=%b required %h 1", bus_wrap.out_data, bus_wrap.out_ovf, CW'(-MAXC - 1));
        end
        drain();
        send(2, 3, 4, 1'b1, 1'b1);
        idle_in();
        wait_out("ovf_clear", k);
        checks++;
        if (bus_sat.out_ovf !== 1'b0 || bus_wrap.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf sat=%b wrap=%b required 0 0", bus_sat.out_ovf, bus_wrap.out_ovf);
        end
        drain();
        // Overflow inside the product+addend step, and moving away from a clamped sum.
        send(1, 1, MAXC, 1'b1, 1'b1);
        send(0, 0, MAXC, 1'b1, 1'b0);
        send(1, 1, 0, 1'b0, 1'b0);
        send(-1, 1, 0, 1'b0, 1'b1);
        idle_in();
        drain();
    endtask

    task automatic test_backpressure();
        saw_stall = 1'b0;
        bp_hold = 10;
        for (int i = 0; i < 12; i++) send(i + 1, -(i + 2), 3 * i, (i % 3) == 0, (i % 3) == 2);
        idle_in();
        drain();
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_stall: in_ready dropped=%b required 1", saw_stall);
        end
    endtask

    task automatic test_random();
        logic signed [AW-1:0] ra;
        logic signed [BW-1:0] rb;
        logic signed [CW-1:0] rc;
        logic signed [15:0]   s16;
        bp_random = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            ra  = AW'($urandom);
            rb  = BW'($urandom);
            s16 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rc = CW'({$urandom, $urandom});
            else                           rc = CW'(s16);
            send(ra, rb, rc, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end
        idle_in();
        bp_random = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_sum();
        int k;
        send(1, 1, 1, 1'b1, 1'b0);
        send(2, 2, 2, 1'b0, 1'b0);
        send(3, 3, 3, 1'b0, 1'b0);
        idle_in();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_sat.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: in_ready=%b required 0", bus_sat.in_ready);
        end
        rst = 1'b1;
        acc_m = '{0, 0};
        ovf_m = '{1'b0, 1'b0};
        send(5, 5, 0, 1'b1, 1'b1);
        idle_in();
        wait_out("reset_mid_sum", k);
        checks++;
        if (bus_sat.out_data !== CW'(25) || bus_wrap.out_data !== CW'(25)) begin
            errors++;
            $display("FAIL mid_reset_value: data=%h required %h", bus_sat.out_data, CW'(25));
        end
        drain();
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation still running at time %0t required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_dot_product();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_reset_mid_sum();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
